gfx_wbm_rr_arbiter: RTL

- Parametrised N-master to 1-slave read/write arbiter for the GFX Wishbone master port.
- Successor to the fixed 5-master combinational priority mux.
- Adds a registered grant that is locked for the duration of a transaction.
- Selectable round-robin or fixed-priority arbitration, plus a burst-hold limit that prevents starvation.
- Sits between the pipeline masters (clip, fragment, blender, textblit, writer, …) and the wbm read/write module.

---
 rtl/gfx_pkg.sv | 12 +
 rtl/gfx_arb_pick.sv | 39 +++
 rtl/gfx_wbm_rr_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// Shared types and constants for the GFX Wishbone master arbitration logic.
package gfx_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    localparam int ARB_MODE_RR    = 1;
    localparam int ARB_MODE_FIXED = 0;

endpackage

// File: rtl/gfx_arb_pick.sv
// Combinational request picker: rotating priority after ptr_i (RR=1) or
// highest requesting index (RR=0).
module gfx_arb_pick
    import gfx_pkg::*;
#(
    parameter int NM = 5,
    parameter int RR = ARB_MODE_RR
) (
    input  logic [NM-1:0]         req_i,
    input  logic [$clog2(NM)-1:0] ptr_i,
    output logic [NM-1:0]         onehot_o,
    output logic [$clog2(NM)-1:0] idx_o,
    output logic                  any_o
);

    localparam int IW = $clog2(NM);

    logic [IW-1:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        cand     = '0;
        any_o    = |req_i;
        if (RR == ARB_MODE_RR) begin
            // Walk from the lowest-priority offset up so the slot nearest ptr+1 is written last.
            for (int i = NM; i >= 1; i--) begin
                cand = IW'((int'(ptr_i) + i) % NM);
                if (req_i[cand]) idx_o = cand;
            end
        end else begin
            for (int i = 0; i < NM; i++) begin
                if (req_i[i]) idx_o = IW'(i);
            end
        end
        if (any_o) onehot_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/gfx_wbm_rr_arbiter.sv
// N-master to 1-slave Wishbone arbiter with a registered, transaction-locked
// grant, round-robin or fixed priority, and a burst-hold limit.
module gfx_wbm_rr_arbiter
    import gfx_pkg::*;
#(
    parameter int NM       = 5,
    parameter int MDW      = 256,
    parameter int AW       = 32,
    parameter int RR       = ARB_MODE_RR,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NM-1:0]         m_read_request_i,
    input  logic [NM-1:0]         m_write_request_i,
    input  logic [NM*AW-1:0]      m_addr_i,
    input  logic [NM*MDW/8-1:0]   m_sel_i,
    input  logic [NM*MDW-1:0]     m_dat_i,
    output logic [MDW-1:0]        m_dat_o,
    output logic [NM-1:0]         m_ack_o,
    output logic [NM-1:0]         grant_o,
    output logic                  master_busy_o,
    output logic                  read_request_o,
    output logic                  write_request_o,
    output logic [AW-1:0]         addr_o,
    output logic                  we_o,
    output logic [MDW/8-1:0]      sel_o,
    output logic [MDW-1:0]        dat_o,
    input  logic [MDW-1:0]        dat_i,
    input  logic                  ack_i
);

    localparam int IW      = $clog2(NM);
    localparam int SW      = MDW / 8;
    localparam int HCW     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int HC_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    // Saturating at the release threshold keeps a late-arriving waiter able to preempt.
    localparam int HC_SAT  = (MAX_HOLD == 0) ? 1 : HC_LAST;

    arb_state_t    state_q, state_d;
    logic [NM-1:0] grant_q, grant_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hc_q, hc_d;

    logic [NM-1:0] req;
    logic [NM-1:0] pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          own;
    logic          g_rd;
    logic          g_wr;
    logic          others_waiting;
    logic          hold_hit;

    assign req            = m_read_request_i | m_write_request_i;
    assign own            = (state_q == ARB_OWN);
    assign g_rd           = m_read_request_i[gidx_q];
    assign g_wr           = m_write_request_i[gidx_q];
    assign others_waiting = |(req & ~grant_q);

    gfx_arb_pick #(
        .NM (NM),
        .RR (RR)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        ptr_d    = ptr_q;
        hc_d     = hc_q;
        hold_hit = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_OWN;
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    ptr_d   = pick_idx;
                    hc_d    = '0;
                end
            end
            ARB_OWN: begin
                if (ack_i && (hc_q != HCW'(HC_SAT))) hc_d = hc_q + 1'b1;
                hold_hit = (MAX_HOLD != 0) && ack_i && (hc_q == HCW'(HC_LAST)) && others_waiting;
                if (!(g_rd || g_wr) || hold_hit) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= IW'(NM - 1);
            hc_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            hc_q    <= hc_d;
        end
    end

    always_comb begin
        read_request_o  = 1'b0;
        write_request_o = 1'b0;
        we_o            = 1'b0;
        addr_o          = '0;
        sel_o           = '0;
        dat_o           = '0;
        if (own) begin
            read_request_o  = g_rd & ~g_wr;
            write_request_o = g_wr;
            we_o            = g_wr;
            addr_o          = m_addr_i[int'(gidx_q)*AW +: AW];
            sel_o           = m_sel_i[int'(gidx_q)*SW +: SW];
            dat_o           = m_dat_i[int'(gidx_q)*MDW +: MDW];
        end
    end

    assign m_dat_o       = dat_i;
    assign m_ack_o       = {NM{ack_i}} & grant_q;
    assign grant_o       = grant_q;
    assign master_busy_o = |req;

endmodule
